// File: rtl/div_ctrl_8_if.sv
// ----------------------------------------------------------------------------
// div_ctrl_8_if
// Request/result bundle for the 8-bit restoring divider.
//
// Signals:
//   start        requester -> divider  request a division (sampled only in IDLE)
//   dividend[8]  requester -> divider  unsigned dividend, captured on accept
//   divisor[8]   requester -> divider  unsigned divisor, captured on accept
//   busy         divider -> requester  high whenever the divider is not IDLE
//   done         divider -> requester  one-cycle pulse, results valid
//   quotient[8]  divider -> requester  unsigned quotient
//   remainder[8] divider -> requester  unsigned remainder
//   div_by_zero  divider -> requester  captured divisor was zero
//
// Modports: master = requester side, slave = divider side.
// ----------------------------------------------------------------------------
interface div_ctrl_8_if;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/div_ctrl_8.sv
// ----------------------------------------------------------------------------
// div_ctrl_8
// 8-bit unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   i_clk   rising-edge clock for all state
//   i_rst   synchronous active-high reset
//   io_bus  div_ctrl_8_if.slave: start/dividend/divisor in,
//           busy/done/quotient/remainder/div_by_zero out
//
// Timing: start accepted at edge k -> 8 RUN cycles -> DONE state -> done
// pulse in the cycle after edge k+9. A zero divisor skips RUN, so done
// appears in the cycle after edge k+1. busy and done are plain registers.
// ----------------------------------------------------------------------------
module div_ctrl_8 (
    input  logic        i_clk,
    input  logic        i_rst,
    div_ctrl_8_if.slave io_bus
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e     r_state;
    state_e     w_state_nxt;

    // Working registers: r_q shifts in quotient bits, r_r holds the partial
    // remainder. They double as the result outputs once DONE is reached.
    logic [7:0] r_q;
    logic [7:0] w_q_nxt;
    logic [7:0] r_r;
    logic [7:0] w_r_nxt;
    logic [7:0] r_divisor;
    logic [7:0] w_divisor_nxt;
    logic [2:0] r_count;
    logic [2:0] w_count_nxt;
    logic       r_dbz;
    logic       w_dbz_nxt;
    logic       r_busy;
    logic       r_done;

    // Single restoring step datapath
    logic [8:0] w_t;
    logic [7:0] w_diff;
    logic       w_borrow;
    logic       w_accept;

    always_comb begin
        w_t                = {r_r, r_q[7]};
        {w_borrow, w_diff} = {1'b0, w_t[7:0]} - {1'b0, r_divisor};
        // T[8] set means T >= 256 > divisor, so the subtract always fits
        // even though the 8-bit datapath reports a borrow.
        w_accept           = w_t[8] | ~w_borrow;
    end

    // Next-state and datapath updates
    always_comb begin
        w_state_nxt   = r_state;
        w_q_nxt       = r_q;
        w_r_nxt       = r_r;
        w_divisor_nxt = r_divisor;
        w_count_nxt   = r_count;
        w_dbz_nxt     = r_dbz;

        unique case (r_state)
            StIdle: begin
                if (io_bus.start) begin
                    w_divisor_nxt = io_bus.divisor;
                    w_count_nxt   = 3'd0;
                    if (io_bus.divisor != 8'd0) begin
                        w_q_nxt     = io_bus.dividend;
                        w_r_nxt     = 8'd0;
                        w_dbz_nxt   = 1'b0;
                        w_state_nxt = StRun;
                    end else begin
                        w_q_nxt     = 8'hFF;
                        w_r_nxt     = io_bus.dividend;
                        w_dbz_nxt   = 1'b1;
                        w_state_nxt = StDone;
                    end
                end
            end

            StRun: begin
                w_q_nxt     = {r_q[6:0], w_accept};
                w_r_nxt     = w_accept ? w_diff : w_t[7:0];
                w_count_nxt = r_count + 3'd1;
                if (r_count == 3'd7) begin
                    w_state_nxt = StDone;
                end
            end

            StDone: begin
                w_state_nxt = StIdle;
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_q       <= 8'd0;
            r_r       <= 8'd0;
            r_divisor <= 8'd0;
            r_count   <= 3'd0;
            r_dbz     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_q       <= w_q_nxt;
            r_r       <= w_r_nxt;
            r_divisor <= w_divisor_nxt;
            r_count   <= w_count_nxt;
            r_dbz     <= w_dbz_nxt;
            // busy tracks the state register exactly, without a decode path
            r_busy    <= (w_state_nxt != StIdle);
            // done pulses the cycle after DONE, so it never depends on start
            r_done    <= (r_state == StDone);
        end
    end

    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
    assign io_bus.quotient    = r_q;
    assign io_bus.remainder   = r_r;
    assign io_bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_ctrl_8.sv
// ----------------------------------------------------------------------------
// tb_div_ctrl_8
// Directed and random checks for div_ctrl_8. Expected results are queued
// when a start is driven and compared when done pulses, including the edge
// at which done is expected.
// ----------------------------------------------------------------------------
module tb_div_ctrl_8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         done_edge;
    } exp_t;

    logic clk;
    logic rst;
    int   edge_n;
    int   n_cmp;
    int   n_mis;
    exp_t sb[$];

    div_ctrl_8_if u_if ();

    div_ctrl_8 u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        edge_n = 0;
        n_cmp  = 0;
        n_mis  = 0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: counts edges and scores every done pulse against the queue
    always begin
        @(posedge clk);
        edge_n = edge_n + 1;
        #2;
        if (u_if.done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", 32'(u_if.done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 32'(u_if.quotient), 32'(e.q));
                check("remainder", 32'(u_if.remainder), 32'(e.r));
                check("div_by_zero", 32'(u_if.div_by_zero), 32'(e.dbz));
                check("done_edge", 32'(edge_n), 32'(e.done_edge));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected result for a start that the next edge will accept
    task automatic push_exp(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q         = 8'hFF;
            e.r         = a;
            e.dbz       = 1'b1;
            e.done_edge = edge_n + 1 + 1;
        end else begin
            e.q         = a / b;
            e.r         = a % b;
            e.dbz       = 1'b0;
            e.done_edge = edge_n + 1 + 9;
        end
        sb.push_back(e);
    endtask

    // Pulse start for one edge, then scramble operands to prove capture
    task automatic launch(input logic [7:0] a, input logic [7:0] b);
        push_exp(a, b);
        u_if.start    = 1'b1;
        u_if.dividend = a;
        u_if.divisor  = b;
        tick();
        u_if.start    = 1'b0;
        u_if.dividend = 8'($urandom);
        u_if.divisor  = 8'($urandom);
        check("busy_after_start", 32'(u_if.busy), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            tick();
        end
        check("drain", 32'(sb.size()), 32'd0);
        tick();
    endtask

    task automatic do_div(input logic [7:0] a, input logic [7:0] b);
        launch(a, b);
        drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d results pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start held high: reset must win
        rst           = 1'b1;
        u_if.start    = 1'b1;
        u_if.dividend = 8'd1;
        u_if.divisor  = 8'd1;
        tick();
        tick();
        check("rst_busy", 32'(u_if.busy), 32'd0);
        check("rst_done", 32'(u_if.done), 32'd0);
        check("rst_quotient", 32'(u_if.quotient), 32'd0);
        check("rst_remainder", 32'(u_if.remainder), 32'd0);
        check("rst_dbz", 32'(u_if.div_by_zero), 32'd0);
        u_if.start = 1'b0;
        rst        = 1'b0;
        tick();
        check("idle_busy", 32'(u_if.busy), 32'd0);

        // Basic and boundary divisions
        do_div(8'd100, 8'd7);
        check("hold_quotient", 32'(u_if.quotient), 32'd14);
        check("hold_remainder", 32'(u_if.remainder), 32'd2);
        do_div(8'd255, 8'd1);
        do_div(8'd255, 8'd128);
        do_div(8'd5, 8'd9);
        do_div(8'd0, 8'd3);
        do_div(8'd255, 8'd255);

        // Divide by zero, flag held, then cleared by the next start
        do_div(8'd200, 8'd0);
        tick();
        check("dbz_held", 32'(u_if.div_by_zero), 32'd1);
        check("dbz_rem_held", 32'(u_if.remainder), 32'd200);
        do_div(8'd10, 8'd3);

        // Start during RUN cycle 3 is ignored
        launch(8'd100, 8'd7);
        repeat (3) tick();
        u_if.start    = 1'b1;
        u_if.dividend = 8'd50;
        u_if.divisor  = 8'd5;
        tick();
        u_if.start    = 1'b0;
        drain();

        // Reset during RUN cycle 4 aborts without a done pulse
        launch(8'd100, 8'd7);
        repeat (4) tick();
        rst = 1'b1;
        sb.delete();
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(u_if.busy), 32'd0);
        check("abort_done", 32'(u_if.done), 32'd0);
        check("abort_quotient", 32'(u_if.quotient), 32'd0);
        check("abort_remainder", 32'(u_if.remainder), 32'd0);
        check("abort_dbz", 32'(u_if.div_by_zero), 32'd0);
        repeat (12) tick();
        do_div(8'd9, 8'd2);

        // Start held high: back-to-back accepts 10 edges apart; the operand
        // change mid-run only affects the second division
        push_exp(8'd20, 8'd6);
        u_if.start    = 1'b1;
        u_if.dividend = 8'd20;
        u_if.divisor  = 8'd6;
        repeat (4) tick();
        u_if.dividend = 8'd30;
        begin
            exp_t e;
            e.q         = 8'd5;
            e.r         = 8'd0;
            e.dbz       = 1'b0;
            e.done_edge = edge_n + 7 + 9;
            sb.push_back(e);
        end
        repeat (10) tick();
        u_if.start = 1'b0;
        drain();

        // Random operand pairs, divisor never zero
        for (int i = 0; i < 1500; i++) begin
            do_div(8'($urandom), 8'($urandom_range(1, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
